// File: rtl/montgomery_multicore_ctrl.sv
// Command controller for an array of Montgomery cores: decodes mailbox commands,
// moves operands/results between BRAM and the cores, and reports a status word.
module montgomery_multicore_ctrl #(
  parameter int DATA_W  = 512,
  parameter int N_CORES = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [N_CORES*DATA_W-1:0]   bram_din,
  input  logic                        bram_din_valid,
  output logic [N_CORES*DATA_W-1:0]   bram_dout,
  output logic [N_CORES-1:0]          bram_dout_valid,
  input  logic                        bram_dout_read,
  input  logic [31:0]                 port1_din,
  input  logic                        port1_valid,
  output logic                        port1_read,
  output logic [31:0]                 port2_dout,
  output logic                        port2_valid,
  input  logic                        port2_read,
  output logic [N_CORES*DATA_W-1:0]   core_operand,
  output logic [N_CORES-1:0]          core_start,
  input  logic [N_CORES-1:0]          core_done,
  input  logic [N_CORES*DATA_W-1:0]   core_result,
  output logic [3:0]                  leds
);

  // state | meaning
  // IDLE  | waiting for a command on port1
  // READ  | loading operands from bram_din into masked cores
  // START | one-cycle start pulse to masked cores
  // WAIT  | collecting done/results from masked cores
  // WRITE | presenting results to BRAM until bram_dout_read
  // DONE  | status word on port2 until port2_read
  typedef enum logic [3:0] {
    S_IDLE  = 4'd7,
    S_READ  = 4'd4,
    S_START = 4'd1,
    S_WAIT  = 4'd6,
    S_WRITE = 4'd5,
    S_DONE  = 4'd3
  } state_t;

  state_t state, state_nx;

  logic [3:0]                cmd_op;
  logic [7:0]                cmd_mask;
  logic                      err;
  logic [N_CORES-1:0]        mask;
  logic [N_CORES-1:0]        sticky;
  logic [N_CORES-1:0]        hit;
  logic [N_CORES*DATA_W-1:0] operand_q;
  logic [N_CORES*DATA_W-1:0] result_q;
  logic [3:0]                in_op;
  logic [N_CORES-1:0]        in_mask;
  logic                      in_err;
  logic                      accept;
  logic                      unused_din;

  assign in_op      = port1_din[3:0];
  assign in_mask    = port1_din[8 +: N_CORES];
  assign in_err     = (in_op > 4'd2) || (in_mask == '0);
  assign accept     = (state == S_IDLE) && port1_valid;
  assign mask       = cmd_mask[N_CORES-1:0];
  assign hit        = core_done & mask;
  assign unused_din = &{1'b0, port1_din[31:16], port1_din[7:4]};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (port1_valid) begin
          if (in_err)              state_nx = S_DONE;
          else if (in_op == 4'd0)  state_nx = S_READ;
          else if (in_op == 4'd1)  state_nx = S_START;
          else                     state_nx = S_WRITE;
        end
      end
      S_READ:  if (bram_din_valid) state_nx = S_DONE;
      S_START: state_nx = S_WAIT;
      // the last done and the exit share one edge, hence the unregistered hit term
      S_WAIT:  if ((sticky | hit) == mask) state_nx = S_DONE;
      S_WRITE: if (bram_dout_read) state_nx = S_DONE;
      S_DONE:  if (port2_read) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_IDLE;
      cmd_op          <= '0;
      cmd_mask        <= '0;
      err             <= 1'b0;
      sticky          <= '0;
      operand_q       <= '0;
      result_q        <= '0;
      port1_read      <= 1'b0;
      port2_valid     <= 1'b0;
      port2_dout      <= '0;
      bram_dout_valid <= '0;
    end else begin
      state           <= state_nx;
      port1_read      <= accept;
      port2_valid     <= (state == S_DONE);
      bram_dout_valid <= (state == S_WRITE) ? mask : '0;

      if (accept) begin
        cmd_op   <= in_op;
        cmd_mask <= port1_din[15:8];
        err      <= in_err;
      end

      if (state == S_DONE)
        port2_dout <= {err, 15'b0, cmd_mask, 4'b0, cmd_op};

      if (state == S_READ && bram_din_valid) begin
        for (int i = 0; i < N_CORES; i++)
          if (mask[i]) operand_q[i*DATA_W +: DATA_W] <= bram_din[i*DATA_W +: DATA_W];
      end

      if (state == S_START)
        sticky <= '0;

      if (state == S_WAIT) begin
        sticky <= sticky | hit;
        for (int i = 0; i < N_CORES; i++)
          if (hit[i]) result_q[i*DATA_W +: DATA_W] <= core_result[i*DATA_W +: DATA_W];
      end
    end
  end

  assign core_start   = (state == S_START) ? mask : '0;
  assign bram_dout    = result_q;
  assign core_operand = operand_q;
  assign leds         = state;

endmodule

// File: tb/tb_montgomery_multicore_ctrl.sv
// Directed bench for montgomery_multicore_ctrl; status words are checked by a
// scoreboard monitor, data/timing checks are made inline by the stimulus.
module tb_montgomery_multicore_ctrl;
  localparam int DW = 512;
  localparam int NC = 2;

  logic               clk;
  logic               resetn;
  logic [NC*DW-1:0]   bram_din;
  logic               bram_din_valid;
  logic [NC*DW-1:0]   bram_dout;
  logic [NC-1:0]      bram_dout_valid;
  logic               bram_dout_read;
  logic [31:0]        port1_din;
  logic               port1_valid;
  logic               port1_read;
  logic [31:0]        port2_dout;
  logic               port2_valid;
  logic               port2_read;
  logic [NC*DW-1:0]   core_operand;
  logic [NC-1:0]      core_start;
  logic [NC-1:0]      core_done;
  logic [NC*DW-1:0]   core_result;
  logic [3:0]         leds;

  montgomery_multicore_ctrl #(.DATA_W(DW), .N_CORES(NC)) dut (
    .clk(clk), .resetn(resetn),
    .bram_din(bram_din), .bram_din_valid(bram_din_valid),
    .bram_dout(bram_dout), .bram_dout_valid(bram_dout_valid), .bram_dout_read(bram_dout_read),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .port2_dout(port2_dout), .port2_valid(port2_valid), .port2_read(port2_read),
    .core_operand(core_operand), .core_start(core_start), .core_done(core_done),
    .core_result(core_result), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int bdv_cnt = 0;
  logic p2v_prev = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one status word per rising port2_valid
  always @(negedge clk) begin
    if (port2_valid && !p2v_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL status_unexpected: got %0h expected none", port2_dout);
      end else begin
        chk("status_word", port2_dout, exp_q.pop_front());
      end
    end
    p2v_prev = port2_valid;
    if (|core_start) start_cnt++;
    if (|bram_dout_valid) bdv_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [7:0] m);
    logic e;
    e = (op > 4'd2) || (m[NC-1:0] == '0);
    exp_q.push_back({e, 15'b0, m, 4'b0, op});
    port1_din   = {16'b0, m, 4'b0, op};
    port1_valid = 1'b1;
    tick();
    port1_valid = 1'b0;
    chk("port1_read_pulse", port1_read, 1);
  endtask

  task automatic wait_status();
    int n = 0;
    while (!port2_valid && n < 20) begin
      tick();
      n++;
    end
    chk("status_wait", port2_valid, 1);
    repeat (3) begin
      tick();
      chk("p2v_hold", port2_valid, 1);
      chk("done_hold", leds, 4'h3);
    end
    port2_read = 1'b1;
    tick();
    port2_read = 1'b0;
    chk("idle_after_read", leds, 4'h7);
    tick();
    chk("p2v_fall", port2_valid, 0);
  endtask

  logic [DW-1:0] va, vb, r1, jn, c0, c0b, c1, dd;
  int s0, b0;

  initial begin
    va  = {16{32'hA0A0_0001}};
    vb  = {16{32'hB0B0_0002}};
    r1  = {64{8'h5A}};
    jn  = {16{32'hDEAD_BEEF}};
    c0  = {16{32'hC0C0_0010}};
    c0b = {16{32'hC0C0_0B0B}};
    c1  = {16{32'hC1C1_0011}};
    dd  = {16{32'h0D0D_D00D}};
    resetn = 1'b0; bram_din = '0; bram_din_valid = 1'b0; bram_dout_read = 1'b0;
    port1_din = '0; port1_valid = 1'b0; port2_read = 1'b0; core_done = '0; core_result = '0;
    repeat (3) tick();
    chk("rst_leds", leds, 4'h7);
    chk("rst_port1_read", port1_read, 0);
    chk("rst_port2_valid", port2_valid, 0);
    chk("rst_port2_dout", port2_dout, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_bdv", bram_dout_valid, 0);
    chk("rst_operand", core_operand, 0);
    chk("rst_result", bram_dout, 0);
    resetn = 1'b1;
    tick();

    // READ mask=3
    send_cmd(4'd0, 8'h03);
    chk("read_state", leds, 4'h4);
    bram_din = {vb, va};
    bram_din_valid = 1'b1;
    tick();
    bram_din_valid = 1'b0;
    chk("read_operand", core_operand, {vb, va});
    chk("port1_read_once", port1_read, 0);
    chk("read_to_done", leds, 4'h3);
    wait_status();

    // COMPUTE mask=2, spurious unmasked done from core 0
    send_cmd(4'd1, 8'h02);
    chk("c2_start", core_start, 2'b10);
    s0 = start_cnt;
    tick();
    chk("c2_start_len", start_cnt, s0 + 1);
    chk("c2_start_off", core_start, 0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) begin core_done = 2'b01; core_result = {r1, jn}; end
      else if (c == 10) begin core_done = 2'b10; core_result = {r1, jn}; end
      else core_done = '0;
      tick();
      core_done = '0;
      chk("c2_state", leds, (c < 10) ? 4'h6 : 4'h3);
    end
    chk("c2_res1", bram_dout[DW +: DW], r1);
    chk("c2_res0", bram_dout[0 +: DW], 0);
    wait_status();

    // COMPUTE mask=3, done during START ignored, repeated done overwrites
    send_cmd(4'd1, 8'h03);
    chk("c3_start", core_start, 2'b11);
    core_done = 2'b10; core_result = {jn, jn};
    tick();
    core_done = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) begin core_done = 2'b01; core_result = {jn, c0}; end
      else if (c == 8) begin core_done = 2'b01; core_result = {jn, c0b}; end
      else if (c == 12) begin core_done = 2'b10; core_result = {c1, jn}; end
      else core_done = '0;
      tick();
      core_done = '0;
      chk("c3_state", leds, (c < 12) ? 4'h6 : 4'h3);
      if (c == 11) chk("c3_res1_kept", bram_dout[DW +: DW], r1);
    end
    chk("c3_results", bram_dout, {c1, c0b});
    wait_status();

    // WRITE mask=1 with a slow reader
    send_cmd(4'd2, 8'h01);
    chk("wr_bdv_first", bram_dout_valid, 0);
    repeat (20) begin
      tick();
      chk("wr_bdv_hold", bram_dout_valid, 2'b01);
      chk("wr_state", leds, 4'h5);
    end
    bram_dout_read = 1'b1;
    tick();
    bram_dout_read = 1'b0;
    chk("wr_to_done", leds, 4'h3);
    chk("wr_bdv_lag", bram_dout_valid, 2'b01);
    tick();
    chk("wr_bdv_fall", bram_dout_valid, 0);
    chk("wr_dout", bram_dout, {c1, c0b});
    wait_status();

    // error commands
    s0 = start_cnt; b0 = bdv_cnt;
    send_cmd(4'd9, 8'h03);
    chk("bad_op_done", leds, 4'h3);
    wait_status();
    send_cmd(4'd1, 8'h00);
    chk("zero_mask_done", leds, 4'h3);
    wait_status();
    chk("err_no_start", start_cnt, s0);
    chk("err_no_bdv", bdv_cnt, b0);

    // reset during WAIT, then a normal minimum-latency COMPUTE
    send_cmd(4'd1, 8'h01);
    repeat (3) tick();
    chk("wait_before_rst", leds, 4'h6);
    void'(exp_q.pop_back());
    s0 = start_cnt;
    resetn = 1'b0;
    tick();
    chk("mid_rst_leds", leds, 4'h7);
    chk("mid_rst_port1_read", port1_read, 0);
    chk("mid_rst_p2v", port2_valid, 0);
    chk("mid_rst_p2d", port2_dout, 0);
    chk("mid_rst_start", core_start, 0);
    chk("mid_rst_bdv", bram_dout_valid, 0);
    chk("mid_rst_dout", bram_dout, 0);
    chk("mid_rst_operand", core_operand, 0);
    resetn = 1'b1;
    tick();
    chk("rst_no_start", start_cnt, s0);
    send_cmd(4'd1, 8'h01);
    chk("post_rst_start", core_start, 2'b01);
    tick();
    core_done = 2'b01; core_result = {jn, dd};
    tick();
    core_done = '0;
    chk("min_latency_done", leds, 4'h3);
    chk("post_rst_res", bram_dout, {{DW{1'b0}}, dd});
    wait_status();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
